// File: rtl/temp_prevent_ctrl_pkg.sv
// rtl/temp_prevent_ctrl_pkg.sv - state codes and defaults for the temperature-prevention controller
package temp_prevent_ctrl_pkg;

  // State codes are shared with the display/debug logic, so the encoding is fixed.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREVENT = 2'd1,
    ST_HOLD    = 2'd2,
    ST_ALARM   = 2'd3
  } state_t;

  localparam int DEF_STABLE_CYC = 4;
  localparam int DEF_HOLD_CYC   = 16;
  localparam int DEF_BLINK_DIV  = 8;
  localparam int DEF_CNT_W      = 8;

endpackage

// File: rtl/temp_prevent_ctrl_flag_qualifier.sv
// rtl/temp_prevent_ctrl_flag_qualifier.sv - debounces a raw flag over STABLE_CYC consecutive ticks
module flag_qualifier #(
  parameter int STABLE_CYC = 4,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic qual
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYC - 1);

  logic [CNT_W-1:0] cnt;

  // Any tick where raw agrees with qual restarts the run, so short glitches never land.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      qual <= 1'b0;
    end else if (raw == qual) begin
      cnt <= '0;
    end else if (tick) begin
      if (cnt >= LAST) begin
        qual <= raw;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/temp_prevent_ctrl.sv
// rtl/temp_prevent_ctrl.sv - fan/alarm sequencing with flag qualification, alarm latch and fan hold
module temp_prevent_ctrl
  import temp_prevent_ctrl_pkg::*;
#(
  parameter int STABLE_CYC = DEF_STABLE_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC,
  parameter int BLINK_DIV  = DEF_BLINK_DIV,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       temp_preven,
  input  logic       temp_alarm,
  input  logic       ack,
  output logic       fan_on,
  output logic       led_alarm,
  output logic       alarm_latched,
  output logic [1:0] state_o
);

  localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_DIV - 1);

  logic             q_prev;
  logic             q_alarm;
  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] blink_cnt;

  flag_qualifier #(.STABLE_CYC(STABLE_CYC), .CNT_W(CNT_W)) u_qual_prev (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .raw   (temp_preven),
    .qual  (q_prev)
  );

  flag_qualifier #(.STABLE_CYC(STABLE_CYC), .CNT_W(CNT_W)) u_qual_alarm (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .raw   (temp_alarm),
    .qual  (q_alarm)
  );

  // Alarm always wins; an ack seen while the alarm is still qualified leaves no trace.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (q_alarm)     state_nx = ST_ALARM;
        else if (q_prev) state_nx = ST_PREVENT;
      end
      ST_PREVENT: begin
        if (q_alarm)      state_nx = ST_ALARM;
        else if (!q_prev) state_nx = ST_HOLD;
      end
      ST_HOLD: begin
        if (q_alarm)                            state_nx = ST_ALARM;
        else if (q_prev)                        state_nx = ST_PREVENT;
        else if (tick && hold_cnt == HOLD_LAST) state_nx = ST_IDLE;
      end
      ST_ALARM: begin
        if (ack && !q_alarm) state_nx = ST_HOLD;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      hold_cnt      <= '0;
      blink_cnt     <= '0;
      fan_on        <= 1'b0;
      led_alarm     <= 1'b0;
      alarm_latched <= 1'b0;
    end else begin
      state         <= state_nx;
      fan_on        <= (state_nx != ST_IDLE);
      alarm_latched <= (state_nx == ST_ALARM);

      if (state_nx == ST_HOLD && state != ST_HOLD)
        hold_cnt <= HOLD_LD;
      else if (state == ST_HOLD && tick && hold_cnt != '0)
        hold_cnt <= hold_cnt - 1'b1;

      // Entering ALARM restarts the blink phase lit; the LED is dark everywhere else.
      if (state_nx == ST_ALARM && state != ST_ALARM) begin
        led_alarm <= 1'b1;
        blink_cnt <= '0;
      end else if (state_nx == ST_ALARM) begin
        if (tick) begin
          if (blink_cnt >= BLINK_LAST) begin
            led_alarm <= ~led_alarm;
            blink_cnt <= '0;
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
          end
        end
      end else begin
        led_alarm <= 1'b0;
        blink_cnt <= '0;
      end
    end
  end

  assign state_o = state;

endmodule
